synch_gray_nstage: RTL and testbench

//   Parametrised N-stage synchronizer for gray-coded multi-bit values, e.g. async FIFO

---
 rtl/synch_gray_nstage.sv | 98 +++++++++
 tb/tb_synch_gray_nstage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/synch_gray_nstage.sv
// N-stage synchronizer for gray-coded values with binary decode, change/stable flags and
// an optional gray-integrity checker enabled by defining SYNCH_GRAY_CHECK_EN.
module synch_gray_nstage #(
   parameter int DATA_WIDTH  = 8,
   parameter int STAGES      = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic                  changed,
   output logic                  stable,
   output logic                  err_multi
);

   localparam int HCW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_CYCLES);

   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("synch_gray_nstage: DATA_WIDTH must be >= 1");
   end
   if (STAGES < 2) begin : g_bad_stages
      $error("synch_gray_nstage: STAGES must be >= 2");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("synch_gray_nstage: HOLD_CYCLES must be >= 1");
   end

   logic [DATA_WIDTH-1:0] sync_q [STAGES];
   logic [DATA_WIDTH-1:0] prev_q;
   logic [HCW-1:0]        hold_cnt;

   // Reset wipes the whole chain so no stale source value ever reaches data_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= data;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign data_out = sync_q[STAGES-1];

   // Bit i of the binary value is the XOR of all gray bits at or above i.
   always_comb begin
      bin_out = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         bin_out[i] = ^(data_out >> i);
      end
   end

   assign changed = (data_out != prev_q);
   assign stable  = (hold_cnt == HOLD_MAX) && !changed;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         hold_cnt <= '0;
      end else begin
         prev_q <= data_out;
         if (changed) begin
            hold_cnt <= '0;
         end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + HCW'(1);
         end
      end
   end

`ifdef SYNCH_GRAY_CHECK_EN
   logic [DATA_WIDTH-1:0] diff;
   logic                  multi_bit;
   logic                  err_q;

   // x & (x-1) is non-zero exactly when more than one bit of x is set.
   assign diff      = data_out ^ prev_q;
   assign multi_bit = |(diff & (diff - DATA_WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (multi_bit) begin
         err_q <= 1'b1;
      end
   end

   assign err_multi = err_q;
`else
   assign err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_synch_gray_nstage.sv
// Randomized and directed bench for synch_gray_nstage: default 8/2/4 instance plus a
// 4-bit, 3-stage, HOLD_CYCLES=1 instance, both checked against a queue-based model.
module tb_synch_gray_nstage;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic [3:0] data5;

   logic [7:0] data_out, bin_out;
   logic       changed, stable, err_multi;
   logic [3:0] data_out5, bin_out5;
   logic       changed5, stable5, err_multi5;

   int vectors     = 0;
   int miscompares = 0;
   string phase    = "init";

   always #5 clk = ~clk;

   synch_gray_nstage #(.DATA_WIDTH(8), .STAGES(2), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .data(data), .data_out(data_out), .bin_out(bin_out),
      .changed(changed), .stable(stable), .err_multi(err_multi)
   );

   synch_gray_nstage #(.DATA_WIDTH(4), .STAGES(3), .HOLD_CYCLES(1)) dut5 (
      .clk(clk), .rst(rst), .data(data5), .data_out(data_out5), .bin_out(bin_out5),
      .changed(changed5), .stable(stable5), .err_multi(err_multi5)
   );

   // Reference model: the chain is a history queue of sampled inputs; stability is the
   // run length of cycles in which the output did not change.
   logic [7:0] hist_a[$];
   logic [3:0] hist_b[$];
   logic [7:0] m_out = '0, m_prev = '0;
   logic [3:0] m5_out = '0, m5_prev = '0;
   int         m_run = 0, m5_run = 0;
   logic       m_err = 1'b0, m5_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         hist_a.delete();
         hist_b.delete();
         for (int i = 0; i < 2; i++) hist_a.push_back(8'h00);
         for (int i = 0; i < 3; i++) hist_b.push_back(4'h0);
         m_out = '0;  m_prev = '0;  m_run = 1;  m_err = 1'b0;
         m5_out = '0; m5_prev = '0; m5_run = 1; m5_err = 1'b0;
      end else begin
         if ($countones(m_out ^ m_prev) > 1) m_err = 1'b1;
         if ($countones(m5_out ^ m5_prev) > 1) m5_err = 1'b1;
         m_prev = m_out;
         hist_a.push_front(data);
         void'(hist_a.pop_back());
         m_out = hist_a[1];
         m_run = (m_out != m_prev) ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
         m5_prev = m5_out;
         hist_b.push_front(data5);
         void'(hist_b.pop_back());
         m5_out = hist_b[2];
         m5_run = (m5_out != m5_prev) ? 0 : ((m5_run < 1000) ? m5_run + 1 : m5_run);
      end
   end

   function automatic logic [7:0] gray8(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [7:0] g2b(input logic [7:0] g);
      for (int b = 0; b < 256; b++) begin
         if (gray8(8'(b)) == g) return 8'(b);
      end
      return 8'h00;
   endfunction

   task automatic expectVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic exp_err, exp_err5;
`ifdef SYNCH_GRAY_CHECK_EN
      exp_err  = m_err;
      exp_err5 = m5_err;
`else
      exp_err  = 1'b0;
      exp_err5 = 1'b0;
`endif
      expectVal({phase, ".data_out"},   data_out,            m_out);
      expectVal({phase, ".bin_out"},    bin_out,             g2b(m_out));
      expectVal({phase, ".changed"},    8'(changed),         8'(m_out != m_prev));
      expectVal({phase, ".stable"},     8'(stable),          8'(m_run >= 5));
      expectVal({phase, ".err_multi"},  8'(err_multi),       8'(exp_err));
      expectVal({phase, ".data_out5"},  8'(data_out5),       8'(m5_out));
      expectVal({phase, ".bin_out5"},   8'(bin_out5),        g2b(8'(m5_out)));
      expectVal({phase, ".changed5"},   8'(changed5),        8'(m5_out != m5_prev));
      expectVal({phase, ".stable5"},    8'(stable5),         8'(m5_run >= 2));
      expectVal({phase, ".err_multi5"}, 8'(err_multi5),      8'(exp_err5));
   endtask

   // Checks the state left by the previous edge, then drives inputs for the next edge.
   task automatic applyStimulus(input logic r, input logic [7:0] d, input logic [3:0] d5);
      @(negedge clk);
      checkOutput();
      rst   = r;
      data  = d;
      data5 = d5;
   endtask

   initial begin
      int pos8, pos4;
      logic [7:0] d;
      logic [3:0] d5;

      rst = 1'b1; data = 8'hA5; data5 = 4'h0;
      @(negedge clk);
      phase = "reset";
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hA5, 4'h0);
      expectVal("reset.data_out", data_out, 8'h00);
      expectVal("reset.stable", 8'(stable), 8'h00);

      phase = "step";
      applyStimulus(1'b0, 8'hA5, 4'h0);
      applyStimulus(1'b0, 8'hA5, 4'h0);
      expectVal("step.data_out_edge1", data_out, 8'h00);
      applyStimulus(1'b0, 8'hA5, 4'h0);
      expectVal("step.data_out_edge2", data_out, 8'hA5);
      expectVal("step.changed_edge2", 8'(changed), 8'h01);
      applyStimulus(1'b0, 8'hA5, 4'h0);
      expectVal("step.changed_edge3", 8'(changed), 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hA5, 4'h0);
      expectVal("step.stable_edge6", 8'(stable), 8'h00);
      applyStimulus(1'b0, 8'hA5, 4'h0);
      expectVal("step.stable_edge7", 8'(stable), 8'h01);

      phase = "sweep5";
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hA5, 4'h0);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      expectVal("sweep5.data_out_edge2", 8'(data_out5), 8'h00);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      expectVal("sweep5.data_out_edge3", 8'(data_out5), 8'h01);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      expectVal("sweep5.stable_edge4", 8'(stable5), 8'h00);
      applyStimulus(1'b0, 8'hA5, 4'h1);
      expectVal("sweep5.stable_edge5", 8'(stable5), 8'h01);

      phase = "graycount";
      for (int i = 0; i <= 256; i++) begin
         d = gray8(i[7:0]);
         applyStimulus(1'b0, d, d[3:0]);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 4'h0);
      expectVal("graycount.wrap_bin", bin_out, 8'h00);

      phase = "violation";
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 4'h0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h03, 4'h3);
`ifdef SYNCH_GRAY_CHECK_EN
      expectVal("violation.err_set", 8'(err_multi), 8'h01);
`else
      expectVal("violation.err_tied", 8'(err_multi), 8'h00);
`endif
      applyStimulus(1'b0, 8'h02, 4'h2);
      applyStimulus(1'b0, 8'h06, 4'h6);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h07, 4'h7);
`ifdef SYNCH_GRAY_CHECK_EN
      expectVal("violation.err_sticky", 8'(err_multi), 8'h01);
`else
      expectVal("violation.err_tied2", 8'(err_multi), 8'h00);
`endif

      phase = "random";
      applyStimulus(1'b1, 8'h00, 4'h0);
      pos8 = 0; pos4 = 0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) == 0) pos8 = (pos8 + (($urandom_range(0, 1) == 0) ? 1 : 255)) % 256;
         if ($urandom_range(0, 2) == 0) pos4 = (pos4 + 1) % 16;
         d  = gray8(8'(pos8));
         d5 = 4'(gray8(8'(pos4)));
         if ($urandom_range(0, 40) == 0) d = 8'($urandom);
         if ($urandom_range(0, 40) == 0) d5 = 4'($urandom);
         applyStimulus(($urandom_range(0, 60) == 0), d, d5);
      end

      phase = "midreset";
      applyStimulus(1'b0, 8'h3C, 4'h5);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h3C, 4'h5);
      expectVal("midreset.stable_before", 8'(stable), 8'h01);
      expectVal("midreset.data_before", data_out, 8'h3C);
      applyStimulus(1'b1, 8'h3D, 4'h4);
      applyStimulus(1'b1, 8'h3D, 4'h4);
      expectVal("midreset.data_out", data_out, 8'h00);
      expectVal("midreset.stable", 8'(stable), 8'h00);
      applyStimulus(1'b0, 8'h3D, 4'h4);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h3D, 4'h4);
      expectVal("midreset.data_after", data_out, 8'h3D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
